uart_rx_core: RTL

UART receiver that pairs with the existing 8N1 transmitter and shares its baud timing. It synchronises the asynchronous rxd line, detects the start-bit falling edge, samples 8 data bits LSB-first at mid-bit, and checks the stop bit. Each received byte goes into a one-entry holding register with a valid/ack handshake. The block sits between the serial pin and the byte-level consumer (FIFO or controller).

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_core_if.sv | 16 +
 rtl/uart_rx_sync.sv | 34 +++
 rtl/uart_rx_core.sv | 139 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, data width and default baud divisor,
// so the transmitter and receiver agree on framing and timing.
package uart_pkg;
  localparam int DATA_BITS         = 8;
  localparam int UART_CLKS_PER_BIT = 501;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_core_if.sv
// Byte-side handshake of the UART receiver: held byte with valid/ack plus
// status pulses. master = receiver, slave = byte consumer.
interface uart_rx_core_if;
  import uart_pkg::*;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ack;
  logic                 frame_err;
  logic                 overrun_err;
  logic                 busy;

  modport master (output rx_data, rx_valid, frame_err, overrun_err, busy,
                  input  rx_ack);
  modport slave  (input  rx_data, rx_valid, frame_err, overrun_err, busy,
                  output rx_ack);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the async rxd pin plus falling-edge detect.
// All flops reset to the idle line level (1).
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic rxd_s,
  output logic fall
);
  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = rxd;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rxd_s = sync_q;
  assign fall  = prev_q & ~sync_q;
endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: mid-bit sampling, stop-bit check, one-entry holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting at every sample point.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rxd,
  uart_rx_core_if.master rx
);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic rxd_s, fall;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .rxd   (rxd),
    .rxd_s (rxd_s),
    .fall  (fall)
  );

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 oerr_q, oerr_d;
  logic                 bit_val;
  logic [CNT_W-1:0]     n_last;

  // Start bit is sampled half a bit in; data/stop a full bit after the previous sample.
  assign n_last = (state_q == START) ? HALF_LAST : BIT_LAST;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] smp_q, smp_d;

  always_comb begin
    smp_d = smp_q;
    if (cnt_q == n_last - CNT_W'(2)) smp_d[0] = rxd_s;
    if (cnt_q == n_last - CNT_W'(1)) smp_d[1] = rxd_s;
  end

  always_ff @(posedge clk) begin
    if (rst) smp_q <= 2'b11;
    else     smp_q <= smp_d;
  end

  assign bit_val = maj3(smp_q[0], smp_q[1], rxd_s);
`else
  assign bit_val = rxd_s;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    oerr_d  = 1'b0;

    if (rx.rx_ack && valid_q) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (cnt_q == n_last) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = bit_val ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == n_last) begin
          cnt_d   = '0;
          shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      STOP: begin
        if (cnt_q == n_last) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!bit_val)     ferr_d = 1'b1;
          else if (valid_q) oerr_d = 1'b1;
          else begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
    end
  end

  assign rx.rx_data     = data_q;
  assign rx.rx_valid    = valid_q;
  assign rx.frame_err   = ferr_q;
  assign rx.overrun_err = oerr_q;
  assign rx.busy        = (state_q != IDLE);
endmodule
